mfree: RTL and testbench

// - Deallocation engine of the MPU, the inverse of the allocator. It takes a region base address from a core, checks it against the ACT, zeroes the region's entries and returns the reservation id to the reservation counter.
// - Sits beside the allocator on the ACT port. Access to that port is muxed externally and is granted while bsy=1.

---
 rtl/mfree.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mfree.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfree.sv
// Region deallocator: validates a region base against the ACT, zeroes the region's entries, returns its reservation id.
// Latency: 5 cycles to the first clear (7 with the predecessor read), then 4 cycles per block; errors finish with no ACT writes.
// Backpressure: none; cs is sampled only while idle, and a request seen while busy is dropped, not queued.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cs, core_id,         free request, requesting core and region base address
//   base_addr
//   act_rdata            ACT read data, valid one cycle after act_addr is presented
//   act_cs/act_we/       ACT access; act_wdata is always zero, so every write clears an entry
//   act_addr/act_wdata
//   rdy, bsy, err,       result strobe (1 cycle), busy flag, error code, number of cleared entries
//   freed_blocks
//   reservation_release, 1-cycle pulse on success returning release_id to the reservation counter
//   release_id
//
// Build option: define MFREE_ROOT_OVERRIDE_EN to let core 0 free regions owned by any core.

package mpu_common_pkg;
   localparam int BLOCK_COUNT      = 16;
   localparam int BLOCK_COUNT_BITS = 4;
   localparam int CORE_COUNT       = 4;
   localparam int CORE_ID_WIDTH    = 2;
   localparam int ADDR_WIDTH       = 16;
   localparam int REGION_SHIFT     = 8;
   // Walk index and block counter are one bit wider so BLOCK_COUNT itself is representable.
   localparam int CNT_WIDTH        = BLOCK_COUNT_BITS + 1;

   localparam logic [1:0] ERR_NONE          = 2'd0;
   localparam logic [1:0] ERR_BAD_ADDR      = 2'd1;
   localparam logic [1:0] ERR_NOT_OWNER     = 2'd2;
   localparam logic [1:0] ERR_NOT_ALLOCATED = 2'd3;

   typedef struct packed {
      logic                        valid;
      logic [CORE_ID_WIDTH-1:0]    owner;
      logic [BLOCK_COUNT_BITS-1:0] rid;
   } entry_t;
endpackage

module mfree
   import mpu_common_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cs,
   input  logic [CORE_ID_WIDTH-1:0]    core_id,
   input  logic [ADDR_WIDTH-1:0]       base_addr,
   input  entry_t                      act_rdata,
   output logic                        act_cs,
   output logic                        act_we,
   output logic [BLOCK_COUNT_BITS-1:0] act_addr,
   output entry_t                      act_wdata,
   output logic                        rdy,
   output logic                        bsy,
   output logic [1:0]                  err,
   output logic [CNT_WIDTH-1:0]        freed_blocks,
   output logic                        reservation_release,
   output logic [BLOCK_COUNT_BITS-1:0] release_id
);

   typedef enum logic [3:0] {
      FREE_IDLE, FREE_LOAD_HEAD, FREE_CHECK_HEAD, FREE_LOAD_PRED, FREE_CHECK_PRED,
      FREE_CLEAR, FREE_NEXT, FREE_LOAD_NEXT, FREE_SCAN, FREE_DONE, FREE_RESULT
   } state_e;

   state_e                      state_q, state_d;
   logic [CNT_WIDTH-1:0]        cur_q, cur_d;
   logic [CNT_WIDTH-1:0]        count_q, count_d;
   logic [CORE_ID_WIDTH-1:0]    core_id_q, core_id_d;
   logic [BLOCK_COUNT_BITS-1:0] rid_q, rid_d;
   logic                        act_cs_q, act_cs_d;
   logic                        act_we_q, act_we_d;
   logic [BLOCK_COUNT_BITS-1:0] act_addr_q, act_addr_d;
   logic                        rdy_q, rdy_d;
   logic                        bsy_q, bsy_d;
   logic [1:0]                  err_q, err_d;
   logic [CNT_WIDTH-1:0]        freed_q, freed_d;
   logic                        rel_q, rel_d;
   logic [BLOCK_COUNT_BITS-1:0] rel_id_q, rel_id_d;

   logic [ADDR_WIDTH-1:0]       idx_full;
   logic                        addr_bad;
   logic                        owner_bad;
   logic [CNT_WIDTH-1:0]        cur_next, cur_prev;

   // All outputs are registered: what a state computes here appears on the pins
   // in the following cycle, which lines the ACT address up with its sync read.
   always_comb begin
      idx_full = base_addr >> REGION_SHIFT;
      addr_bad = (base_addr[REGION_SHIFT-1:0] != '0) ||
                 (idx_full >= ADDR_WIDTH'(BLOCK_COUNT));
      cur_next = cur_q + CNT_WIDTH'(1);
      cur_prev = cur_q - CNT_WIDTH'(1);
`ifdef MFREE_ROOT_OVERRIDE_EN
      owner_bad = (act_rdata.owner != core_id_q) && (core_id_q != '0);
`else
      owner_bad = (act_rdata.owner != core_id_q);
`endif

      state_d    = state_q;
      cur_d      = cur_q;
      count_d    = count_q;
      core_id_d  = core_id_q;
      rid_d      = rid_q;
      act_cs_d   = act_cs_q;
      act_we_d   = act_we_q;
      act_addr_d = act_addr_q;
      rdy_d      = rdy_q;
      bsy_d      = bsy_q;
      err_d      = err_q;
      freed_d    = freed_q;
      rel_d      = rel_q;
      rel_id_d   = rel_id_q;

      case (state_q)
         FREE_IDLE: begin
            if (cs) begin
               core_id_d = core_id;
               cur_d     = idx_full[CNT_WIDTH-1:0];
               count_d   = '0;
               bsy_d     = 1'b1;
               if (addr_bad) begin
                  err_d   = ERR_BAD_ADDR;
                  rdy_d   = 1'b1;
                  state_d = FREE_RESULT;
               end else begin
                  act_cs_d   = 1'b1;
                  act_we_d   = 1'b0;
                  act_addr_d = idx_full[BLOCK_COUNT_BITS-1:0];
                  state_d    = FREE_LOAD_HEAD;
               end
            end
         end
         FREE_LOAD_HEAD: state_d = FREE_CHECK_HEAD;
         FREE_CHECK_HEAD: begin
            if (!act_rdata.valid || owner_bad) begin
               err_d    = !act_rdata.valid ? ERR_NOT_ALLOCATED : ERR_NOT_OWNER;
               act_cs_d = 1'b0;
               rdy_d    = 1'b1;
               state_d  = FREE_RESULT;
            end else begin
               rid_d = act_rdata.rid;
               if (cur_q != '0) begin
                  act_addr_d = cur_prev[BLOCK_COUNT_BITS-1:0];
                  state_d    = FREE_LOAD_PRED;
               end else begin
                  state_d = FREE_CLEAR;
               end
            end
         end
         FREE_LOAD_PRED: state_d = FREE_CHECK_PRED;
         FREE_CHECK_PRED: begin
            // A live predecessor with the same reservation means base is inside the region.
            if (act_rdata.valid && (act_rdata.rid == rid_q)) begin
               err_d    = ERR_BAD_ADDR;
               act_cs_d = 1'b0;
               rdy_d    = 1'b1;
               state_d  = FREE_RESULT;
            end else begin
               state_d = FREE_CLEAR;
            end
         end
         FREE_CLEAR: begin
            act_we_d   = 1'b1;
            act_addr_d = cur_q[BLOCK_COUNT_BITS-1:0];
            count_d    = count_q + CNT_WIDTH'(1);
            state_d    = FREE_NEXT;
         end
         FREE_NEXT: begin
            act_we_d = 1'b0;
            // Stop at the last block instead of wrapping the index back to 0.
            if (cur_next == CNT_WIDTH'(BLOCK_COUNT)) begin
               state_d = FREE_DONE;
            end else begin
               act_addr_d = cur_next[BLOCK_COUNT_BITS-1:0];
               cur_d      = cur_next;
               state_d    = FREE_LOAD_NEXT;
            end
         end
         FREE_LOAD_NEXT: state_d = FREE_SCAN;
         FREE_SCAN: begin
            if (act_rdata.valid && (act_rdata.rid == rid_q)) state_d = FREE_CLEAR;
            else                                            state_d = FREE_DONE;
         end
         FREE_DONE: begin
            act_cs_d = 1'b0;
            rel_d    = 1'b1;
            rel_id_d = rid_q;
            freed_d  = count_q;
            rdy_d    = 1'b1;
            state_d  = FREE_RESULT;
         end
         FREE_RESULT: begin
            rdy_d    = 1'b0;
            bsy_d    = 1'b0;
            err_d    = ERR_NONE;
            freed_d  = '0;
            rel_d    = 1'b0;
            rel_id_d = '0;
            state_d  = FREE_IDLE;
         end
         default: begin
            state_d    = FREE_IDLE;
            cur_d      = '0;
            count_d    = '0;
            core_id_d  = '0;
            rid_d      = '0;
            act_cs_d   = 1'b0;
            act_we_d   = 1'b0;
            act_addr_d = '0;
            rdy_d      = 1'b0;
            bsy_d      = 1'b0;
            err_d      = ERR_NONE;
            freed_d    = '0;
            rel_d      = 1'b0;
            rel_id_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FREE_IDLE;
         cur_q      <= '0;
         count_q    <= '0;
         core_id_q  <= '0;
         rid_q      <= '0;
         act_cs_q   <= 1'b0;
         act_we_q   <= 1'b0;
         act_addr_q <= '0;
         rdy_q      <= 1'b0;
         bsy_q      <= 1'b0;
         err_q      <= ERR_NONE;
         freed_q    <= '0;
         rel_q      <= 1'b0;
         rel_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         count_q    <= count_d;
         core_id_q  <= core_id_d;
         rid_q      <= rid_d;
         act_cs_q   <= act_cs_d;
         act_we_q   <= act_we_d;
         act_addr_q <= act_addr_d;
         rdy_q      <= rdy_d;
         bsy_q      <= bsy_d;
         err_q      <= err_d;
         freed_q    <= freed_d;
         rel_q      <= rel_d;
         rel_id_q   <= rel_id_d;
      end
   end

   assign act_cs              = act_cs_q;
   assign act_we              = act_we_q;
   assign act_addr            = act_addr_q;
   assign act_wdata           = '0;
   assign rdy                 = rdy_q;
   assign bsy                 = bsy_q;
   assign err                 = err_q;
   assign freed_blocks        = freed_q;
   assign reservation_release = rel_q;
   assign release_id          = rel_id_q;

endmodule

// File: tb/tb_mfree.sv
// Bench for mfree: behavioural ACT with sync read, response scoreboard, directed free requests.
// Latency: n/a.
// Backpressure: n/a; requests are issued only while the engine is idle.
module tb_mfree;
   import mpu_common_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        cs;
   logic [CORE_ID_WIDTH-1:0]    core_id;
   logic [ADDR_WIDTH-1:0]       base_addr;
   entry_t                      act_rdata;
   logic                        act_cs, act_we;
   logic [BLOCK_COUNT_BITS-1:0] act_addr;
   entry_t                      act_wdata;
   logic                        rdy, bsy;
   logic [1:0]                  err;
   logic [CNT_WIDTH-1:0]        freed_blocks;
   logic                        reservation_release;
   logic [BLOCK_COUNT_BITS-1:0] release_id;

   mfree dut (
      .clk(clk), .rst(rst), .cs(cs), .core_id(core_id), .base_addr(base_addr),
      .act_rdata(act_rdata), .act_cs(act_cs), .act_we(act_we), .act_addr(act_addr),
      .act_wdata(act_wdata), .rdy(rdy), .bsy(bsy), .err(err), .freed_blocks(freed_blocks),
      .reservation_release(reservation_release), .release_id(release_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]                  err;
      logic [CNT_WIDTH-1:0]        freed;
      logic                        rel;
      logic [BLOCK_COUNT_BITS-1:0] rid;
   } exp_t;

   exp_t   exp_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     rel_count = 0;
   int     wr_count  = 0;
   logic   wdata_bad = 1'b0;
   logic   prev_rdy  = 1'b0;
   logic [BLOCK_COUNT-1:0] wmask = '0;
   entry_t mem [BLOCK_COUNT];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ACT model: synchronous read, write-through of zero entries, write log.
   always @(posedge clk) begin
      if (act_cs) begin
         act_rdata <= mem[act_addr];
         if (act_we) begin
            mem[act_addr] = act_wdata;
            wmask[act_addr] = 1'b1;
            wr_count++;
            if (act_wdata != '0) wdata_bad = 1'b1;
         end
      end
   end

   // Response monitor: every rdy pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rdy) begin
         check("rdy_single_cycle", {31'd0, prev_rdy}, 0);
         check("bsy_with_rdy", {31'd0, bsy}, 1);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rdy: err=%0d freed=%0d with no request outstanding", err, freed_blocks);
         end else begin
            e = exp_q.pop_front();
            check("resp_err", {30'd0, err}, {30'd0, e.err});
            check("resp_freed", 32'(freed_blocks), 32'(e.freed));
            check("resp_release", {31'd0, reservation_release}, {31'd0, e.rel});
            if (e.rel) check("resp_release_id", 32'(release_id), 32'(e.rid));
         end
      end
      if (!rst && reservation_release && !rdy) begin
         n_checks++;
         n_fail++;
         $display("FAIL release_without_rdy: release_id=%0d", release_id);
      end
      if (reservation_release) rel_count++;
      prev_rdy = rdy;
   end

   task automatic clear_mem();
      for (int i = 0; i < BLOCK_COUNT; i++) mem[i] = '0;
   endtask

   task automatic set_ent(input int i, input int owner, input int rid);
      mem[i].valid = 1'b1;
      mem[i].owner = CORE_ID_WIDTH'(owner);
      mem[i].rid   = BLOCK_COUNT_BITS'(rid);
   endtask

   task automatic setup_t1();
      clear_mem();
      for (int i = 3; i <= 5; i++) set_ent(i, 2, 7);
      set_ent(6, 2, 4);
   endtask

   // Issue one request in the current cycle, wait for the engine to go idle, check the write log.
   task automatic do_free(input string name, input int core, input int addr, input logic [1:0] e_err,
                          input int e_freed, input logic e_rel, input int e_rid, input int e_mask);
      exp_t e;
      logic ok;
      e.err   = e_err;
      e.freed = CNT_WIDTH'(e_freed);
      e.rel   = e_rel;
      e.rid   = BLOCK_COUNT_BITS'(e_rid);
      exp_q.push_back(e);
      wmask     = '0;
      cs        = 1'b1;
      core_id   = CORE_ID_WIDTH'(core);
      base_addr = ADDR_WIDTH'(addr);
      @(negedge clk);
      cs = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!bsy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({name, "_done_in_time"}, {31'd0, ok}, 1);
      check({name, "_resp_seen"}, 32'(exp_q.size()), 0);
      exp_q.delete();
      check({name, "_write_mask"}, 32'(wmask), 32'(e_mask));
   endtask

   initial begin
      logic ok;
      rst = 1'b1; cs = 1'b0; core_id = '0; base_addr = '0;
      clear_mem();
      repeat (3) @(negedge clk);
      check("reset_ctl", {26'd0, rdy, bsy, act_cs, act_we, reservation_release, 1'b0}, 0);
      check("reset_err", {30'd0, err}, 0);
      check("reset_data", {23'd0, freed_blocks, release_id}, 0);
      rst = 1'b0;

      // T1: three-block region owned by core 2, neighbour with another rid left alone
      setup_t1();
      do_free("t1", 2, 'h300, ERR_NONE, 3, 1'b1, 7, 'h0038);
      check("t1_blk6_kept", {31'd0, mem[6].valid}, 1);
      check("t1_wdata_zero", {31'd0, wdata_bad}, 0);

      // T2: wrong owner, then core 0
      setup_t1();
      do_free("t2_core1", 1, 'h300, ERR_NOT_OWNER, 0, 1'b0, 0, 'h0000);
      setup_t1();
`ifdef MFREE_ROOT_OVERRIDE_EN
      do_free("t2_core0", 0, 'h300, ERR_NONE, 3, 1'b1, 7, 'h0038);
`else
      do_free("t2_core0", 0, 'h300, ERR_NOT_OWNER, 0, 1'b0, 0, 'h0000);
`endif

      // T3: bad addresses
      setup_t1();
      do_free("t3_mid", 2, 'h400, ERR_BAD_ADDR, 0, 1'b0, 0, 'h0000);
      do_free("t3_misalign", 2, 'h310, ERR_BAD_ADDR, 0, 1'b0, 0, 'h0000);
      do_free("t3_range", 2, 'h1000, ERR_BAD_ADDR, 0, 1'b0, 0, 'h0000);

      // T4: unallocated head, owner field set but valid clear
      clear_mem();
      mem[9].owner = 2'd2;
      mem[9].rid   = 4'd3;
      do_free("t4", 2, 'h900, ERR_NOT_ALLOCATED, 0, 1'b0, 0, 'h0000);

      // Region at block 0: no predecessor read
      clear_mem();
      set_ent(0, 3, 1); set_ent(1, 3, 1); set_ent(2, 3, 9);
      do_free("blk0", 3, 'h000, ERR_NONE, 2, 1'b1, 1, 'h0003);

      // T5: region reaching the last block; block 0 carries the same rid to expose a wrap
      clear_mem();
      set_ent(0, 1, 2); set_ent(12, 1, 5);
      for (int i = 13; i <= 15; i++) set_ent(i, 1, 2);
      do_free("t5", 1, 'hD00, ERR_NONE, 3, 1'b1, 2, 'hE000);
      check("t5_blk0_kept", {31'd0, mem[0].valid}, 1);

      // T6: reset after the second write
      setup_t1();
      wr_count = 0;
      cs = 1'b1; core_id = 2'd2; base_addr = 16'h0300;
      @(negedge clk);
      cs = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (wr_count >= 2) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("t6_two_writes_seen", {31'd0, ok}, 1);
      rel_count = 0;
      rst = 1'b1;
      @(negedge clk);
      check("t6_reset_ctl", {27'd0, rdy, bsy, act_cs, act_we, reservation_release}, 0);
      check("t6_reset_err", {30'd0, err}, 0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("t6_blk5_kept", {31'd0, mem[5].valid}, 1);
      check("t6_blk34_cleared", {30'd0, mem[3].valid, mem[4].valid}, 0);
      check("t6_no_release", 32'(rel_count), 0);
      do_free("t6_after", 2, 'h500, ERR_NONE, 1, 1'b1, 7, 'h0020);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
